// File: rtl/synth_pkg.sv
// Shared midi_synth definitions: default field widths, allocator FSM states and
// the per-voice configuration record consumed by the voice bank.
package synth_pkg;

   localparam int NOTE_W_DFLT = 7;
   localparam int VEL_W_DFLT  = 7;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      COMMIT = 2'd2
   } alloc_state_t;

   typedef struct packed {
      logic [NOTE_W_DFLT-1:0] note;
      logic [VEL_W_DFLT-1:0]  vel;
      logic                   gate;
   } voice_cfg_t;

endpackage

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: scans the voice table one slot per cycle, then
// retriggers, fills a free slot or steals the oldest voice with one config write.
module voice_allocator
   import synth_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int NOTE_W     = NOTE_W_DFLT,
   parameter int VEL_W      = VEL_W_DFLT,
   parameter int AGE_W      = 8
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic                          i_evt_valid,
   output logic                          o_evt_ready,
   input  logic                          i_evt_note_on,
   input  logic [NOTE_W-1:0]             i_evt_note,
   input  logic [VEL_W-1:0]              i_evt_vel,
   output logic                          o_voice_wr,
   output logic [$clog2(NUM_VOICES)-1:0] o_voice_idx,
   output logic [NOTE_W-1:0]             o_voice_note,
   output logic [VEL_W-1:0]              o_voice_vel,
   output logic                          o_voice_gate,
   output logic                          o_voice_steal,
   output logic [NUM_VOICES-1:0]         o_active_mask
);

   localparam int                IDX_W    = $clog2(NUM_VOICES);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_VOICES - 1);
   localparam logic [AGE_W-1:0]  AGE_MAX  = '1;

   alloc_state_t state, state_nxt;
   logic [IDX_W-1:0] scan_idx;
   logic             accept;

   logic              ev_on;
   logic [NOTE_W-1:0] ev_note;
   logic [VEL_W-1:0]  ev_vel;

   logic [NUM_VOICES-1:0] active;
   logic [NOTE_W-1:0]     note_tbl [NUM_VOICES];
   logic [AGE_W-1:0]      age_tbl  [NUM_VOICES];

   logic             match_found, match_found_nxt;
   logic             free_found, free_found_nxt;
   logic             old_found, old_found_nxt;
   logic [IDX_W-1:0] match_idx, match_idx_nxt;
   logic [IDX_W-1:0] free_idx, free_idx_nxt;
   logic [IDX_W-1:0] old_idx, old_idx_nxt;
   logic [AGE_W-1:0] old_age, old_age_nxt;

   logic             res_wr;
   logic             res_steal;
   logic [IDX_W-1:0] res_idx;

   assign o_evt_ready   = (state == IDLE) && !i_reset;
   assign accept        = i_evt_valid && o_evt_ready;
   assign o_active_mask = active;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SCAN;
         SCAN:    if (scan_idx == LAST_IDX) state_nxt = COMMIT;
         COMMIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Fold the slot under the scan pointer into the running match/free/oldest picks.
   always_comb begin
      match_found_nxt = match_found;
      match_idx_nxt   = match_idx;
      free_found_nxt  = free_found;
      free_idx_nxt    = free_idx;
      old_found_nxt   = old_found;
      old_idx_nxt     = old_idx;
      old_age_nxt     = old_age;
      if (active[scan_idx]) begin
         if (!match_found && note_tbl[scan_idx] == ev_note) begin
            match_found_nxt = 1'b1;
            match_idx_nxt   = scan_idx;
         end
         if (!old_found || age_tbl[scan_idx] > old_age) begin
            old_found_nxt = 1'b1;
            old_idx_nxt   = scan_idx;
            old_age_nxt   = age_tbl[scan_idx];
         end
      end else if (!free_found) begin
         free_found_nxt = 1'b1;
         free_idx_nxt   = scan_idx;
      end
   end

   always_comb begin
      res_wr    = 1'b0;
      res_steal = 1'b0;
      res_idx   = match_idx_nxt;
      if (ev_on) begin
         res_wr = 1'b1;
         if (match_found_nxt) begin
            res_idx = match_idx_nxt;
         end else if (free_found_nxt) begin
            res_idx = free_idx_nxt;
         end else begin
            res_idx   = old_idx_nxt;
            res_steal = 1'b1;
         end
      end else if (match_found_nxt) begin
         res_wr = 1'b1;
      end
   end

   // Event latch and scan trackers; always initialised on accept, so no reset.
   always_ff @(posedge i_clk) begin
      if (accept) begin
         ev_on       <= i_evt_note_on && (i_evt_vel != '0);
         ev_note     <= i_evt_note;
         ev_vel      <= i_evt_vel;
         match_found <= 1'b0;
         free_found  <= 1'b0;
         old_found   <= 1'b0;
         match_idx   <= '0;
         free_idx    <= '0;
         old_idx     <= '0;
         old_age     <= '0;
      end else if (state == SCAN) begin
         match_found <= match_found_nxt;
         match_idx   <= match_idx_nxt;
         free_found  <= free_found_nxt;
         free_idx    <= free_idx_nxt;
         old_found   <= old_found_nxt;
         old_idx     <= old_idx_nxt;
         old_age     <= old_age_nxt;
      end
   end

   // Control, write port and voice table. The write is registered on the last
   // scan edge so it is visible throughout COMMIT; the table follows on COMMIT's edge.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state         <= IDLE;
         scan_idx      <= '0;
         active        <= '0;
         o_voice_wr    <= 1'b0;
         o_voice_steal <= 1'b0;
         o_voice_idx   <= '0;
         o_voice_note  <= '0;
         o_voice_vel   <= '0;
         o_voice_gate  <= 1'b0;
         for (int i = 0; i < NUM_VOICES; i++) age_tbl[i] <= '0;
      end else begin
         state         <= state_nxt;
         o_voice_wr    <= 1'b0;
         o_voice_steal <= 1'b0;
         case (state)
            IDLE: if (accept) scan_idx <= '0;
            SCAN: begin
               scan_idx <= scan_idx + 1'b1;
               if (scan_idx == LAST_IDX && res_wr) begin
                  o_voice_wr    <= 1'b1;
                  o_voice_steal <= res_steal;
                  o_voice_idx   <= res_idx;
                  o_voice_note  <= ev_note;
                  o_voice_vel   <= ev_on ? ev_vel : '0;
                  o_voice_gate  <= ev_on;
               end
            end
            COMMIT: if (o_voice_wr) begin
               for (int i = 0; i < NUM_VOICES; i++) begin
                  if (IDX_W'(i) == o_voice_idx) begin
                     active[i]   <= o_voice_gate;
                     note_tbl[i] <= o_voice_note;
                     age_tbl[i]  <= '0;
                  end else if (o_voice_gate && active[i] && age_tbl[i] != AGE_MAX) begin
                     age_tbl[i] <= age_tbl[i] + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
